// File: rtl/grf_wb_pkg.sv
// Shared CPU register-file constants and types.
// Used by the register-destination / write-back-data selector stage and by
// the register file itself, so that sizes and the hard-wired zero register
// are defined in one place.
package grf_wb_pkg;

  localparam int unsigned NREG_C = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned DW     = 32;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] word_t;

  localparam reg_addr_t ZERO_REG = '0;

  // One committed write as seen on the trace port.
  typedef struct packed {
    word_t     pc;
    reg_addr_t addr;
    word_t     data;
  } trc_rec_t;

  // A write only takes effect when enabled and not aimed at the zero register.
  function automatic logic is_commit(input logic we, input reg_addr_t waddr);
    return we && (waddr != ZERO_REG);
  endfunction

endpackage

// File: rtl/grf_wb_trace.sv
// grf_trace: write-trace register and committed-write counter.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   commit                  a register write commits at this edge
//   pc, addr, data          the writing instruction's PC, register and data
//   trc_valid               one-cycle strobe following each committed write
//   trc_pc/addr/data        details of the most recent committed write (held)
//   wr_cnt                  number of committed writes, wraps at 2^32
module grf_trace
  import grf_wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      commit,
  input  word_t     pc,
  input  reg_addr_t addr,
  input  word_t     data,
  output logic      trc_valid,
  output word_t     trc_pc,
  output reg_addr_t trc_addr,
  output word_t     trc_data,
  output word_t     wr_cnt
);

  logic     valid_q, valid_d;
  trc_rec_t trc_q, trc_d;
  word_t    cnt_q, cnt_d;

  always_comb begin
    valid_d = commit;
    trc_d   = trc_q;
    cnt_d   = cnt_q;
    if (commit) begin
      trc_d = '{pc: pc, addr: addr, data: data};
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      trc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      trc_q   <= trc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign trc_valid = valid_q;
  assign trc_pc    = trc_q.pc;
  assign trc_addr  = trc_q.addr;
  assign trc_data  = trc_q.data;
  assign wr_cnt    = cnt_q;

endmodule

// File: rtl/grf_wb.sv
// grf_wb: 32 x 32-bit general register file with write-back port, write-first
// bypass on both read ports, and a write trace / commit counter.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   we, waddr, wdata, wpc   write-back port (enable, register, data, PC)
//   raddr1/2, rdata1/2      combinational read ports; r0 always reads 0
//   trc_valid, trc_pc,
//   trc_addr, trc_data      trace of committed writes, one cycle after commit
//   wr_cnt                  count of committed writes
module grf_wb
  import grf_wb_pkg::*;
#(
  parameter int unsigned NREG = NREG_C
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  reg_addr_t waddr,
  input  word_t     wdata,
  input  word_t     wpc,
  input  reg_addr_t raddr1,
  input  reg_addr_t raddr2,
  output word_t     rdata1,
  output word_t     rdata2,
  output logic      trc_valid,
  output word_t     trc_pc,
  output reg_addr_t trc_addr,
  output word_t     trc_data,
  output word_t     wr_cnt
);

  word_t regs_q [NREG];
  word_t regs_d [NREG];
  logic  commit;

  // Gating with rst_n keeps the bypass off while reset is held; the array
  // and trace flops are already forced clear by the asynchronous reset.
  assign commit = rst_n && is_commit(we, waddr);

  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[waddr] = wdata;
    end
    regs_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-first reads: an in-flight write to the same register is visible
  // in the same cycle, so both ports agree when they share an address.
  always_comb begin
    rdata1 = regs_q[raddr1];
    if (raddr1 == ZERO_REG) begin
      rdata1 = '0;
    end else if (commit && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = regs_q[raddr2];
    if (raddr2 == ZERO_REG) begin
      rdata2 = '0;
    end else if (commit && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
  end

  grf_trace u_trace (
    .clk       (clk),
    .rst_n     (rst_n),
    .commit    (commit),
    .pc        (wpc),
    .addr      (waddr),
    .data      (wdata),
    .trc_valid (trc_valid),
    .trc_pc    (trc_pc),
    .trc_addr  (trc_addr),
    .trc_data  (trc_data),
    .wr_cnt    (wr_cnt)
  );

endmodule

// File: tb/tb_grf_wb.sv
module tb_grf_wb;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] wpc;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        trc_valid;
  logic [31:0] trc_pc;
  logic [4:0]  trc_addr;
  logic [31:0] trc_data;
  logic [31:0] wr_cnt;

  grf_wb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .wpc       (wpc),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .trc_valid (trc_valid),
    .trc_pc    (trc_pc),
    .trc_addr  (trc_addr),
    .trc_data  (trc_data),
    .wr_cnt    (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = '0;
  endtask

  // Drive one cycle of stimulus at the falling edge, check the combinational
  // reads against the model, and push any expected trace record.
  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2);
    logic        c;
    logic [31:0] e1, e2;
    exp_t        e;
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; wpc = pc; raddr1 = ra1; raddr2 = ra2;
    #1;
    c  = w && (wa != 5'd0);
    e1 = (ra1 == 5'd0) ? 32'h0 : ((c && ra1 == wa) ? wd : m_regs[ra1]);
    e2 = (ra2 == 5'd0) ? 32'h0 : ((c && ra2 == wa) ? wd : m_regs[ra2]);
    chk_eq("rdata1", rdata1, e1);
    chk_eq("rdata2", rdata2, e2);
    if (c) begin
      m_regs[wa] = wd;
      m_cnt      = m_cnt + 32'd1;
      e.pc = pc; e.addr = wa; e.data = wd; e.cnt = m_cnt;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
    drive(1'b0, 5'd0, 32'h0, 32'h0, ra1, ra2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_rdata1"}, rdata1, 32'h0);
    chk_eq({tag, "_rdata2"}, rdata2, 32'h0);
    chk_eq({tag, "_trc_valid"}, {31'h0, trc_valid}, 32'h0);
    chk_eq({tag, "_trc_pc"}, trc_pc, 32'h0);
    chk_eq({tag, "_trc_addr"}, {27'h0, trc_addr}, 32'h0);
    chk_eq({tag, "_trc_data"}, trc_data, 32'h0);
    chk_eq({tag, "_wr_cnt"}, wr_cnt, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; we = 1'b0;
    model_clear();
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Trace monitor: each cycle, one expected record is due if one was pushed
  // before this edge; otherwise the strobe must be low.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) continue;
      if (!rst_n) begin
        sb_q.delete();
        continue;
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk_eq("trc_valid", {31'h0, trc_valid}, 32'h1);
        chk_eq("trc_pc", trc_pc, e.pc);
        chk_eq("trc_addr", {27'h0, trc_addr}, {27'h0, e.addr});
        chk_eq("trc_data", trc_data, e.data);
        chk_eq("wr_cnt", wr_cnt, e.cnt);
      end else begin
        chk_eq("trc_idle", {31'h0, trc_valid}, 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd;
    logic        w;

    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wpc = '0;
    raddr1 = '0; raddr2 = '0;
    model_clear();
    #3;
    chk_all_zero("init");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // First write after reset, then read back and check the held trace.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 32'h00003000, 5'd0, 5'd5);
    idle(5'd5, 5'd0);
    chk_eq("rd_r5", rdata1, 32'hDEADBEEF);
    idle(5'd5, 5'd5);
    chk_eq("hold_pc", trc_pc, 32'h00003000);
    chk_eq("hold_addr", {27'h0, trc_addr}, 32'd5);
    chk_eq("hold_data", trc_data, 32'hDEADBEEF);
    chk_eq("hold_cnt", wr_cnt, 32'd1);

    // Write to r0 is ignored entirely; r0 is not bypassed.
    drive(1'b1, 5'd0, 32'h12345678, 32'h00003004, 5'd0, 5'd0);
    chk_eq("r0_bypass", rdata1, 32'h0);
    idle(5'd0, 5'd5);
    chk_eq("r0_cnt", wr_cnt, 32'd1);

    // Same-cycle bypass on both ports.
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 32'h00003008, 5'd7, 5'd7);
    chk_eq("byp1", rdata1, 32'hA5A5A5A5);
    chk_eq("byp2", rdata2, 32'hA5A5A5A5);
    idle(5'd7, 5'd7);

    // Back-to-back writes from a clean reset.
    do_reset();
    drive(1'b1, 5'd1, 32'h11111111, 32'h00000100, 5'd0, 5'd0);
    drive(1'b1, 5'd2, 32'h22222222, 32'h00000104, 5'd1, 5'd0);
    drive(1'b1, 5'd3, 32'h33333333, 32'h00000108, 5'd1, 5'd2);
    idle(5'd3, 5'd2);
    chk_eq("b2b_cnt", wr_cnt, 32'd3);

    // Asynchronous reset in the middle of a write to r9.
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h99999999; wpc = 32'h00000200;
    raddr1 = 5'd9; raddr2 = 5'd9;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_clear();
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    idle(5'd9, 5'd1);
    idle(5'd9, 5'd3);

    // Redundant rewrite of the same value still counts and traces.
    drive(1'b1, 5'd4, 32'h0000CAFE, 32'h00000300, 5'd0, 5'd0);
    drive(1'b1, 5'd4, 32'h0000CAFE, 32'h00000304, 5'd4, 5'd0);
    idle(5'd4, 5'd0);
    chk_eq("redundant_cnt", wr_cnt, 32'd2);

    // Random traffic with frequent read/write address collisions.
    for (int i = 0; i < 60; i++) begin
      w   = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(w, wa, wd, $urandom, ra1, ra2);
    end
    idle(5'd0, 5'd0);

    // Counter wrap: preload all-ones, then one committed write.
    idle(5'd0, 5'd0);
    force dut.u_trace.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.u_trace.cnt_q;
    #1;
    chk_eq("preload", wr_cnt, 32'hFFFFFFFF);
    m_cnt = 32'hFFFFFFFF;
    drive(1'b1, 5'd12, 32'h0BADF00D, 32'h00000400, 5'd12, 5'd0);
    idle(5'd12, 5'd0);
    chk_eq("wrap_cnt", wr_cnt, 32'h0);

    idle(5'd0, 5'd0);
    chk_eq("sb_drain", sb_q.size(), 32'd0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
